wb_ddr_arbiter: RTL

- Round-robin Wishbone B3 arbiter that shares the single DDR Wishbone port (upstream of the WB-to-NASTI bridge) between NUM_MASTERS requesters, e.g. the compute tile memory port and a debug/loader port.
- Holds the grant for a whole cycle, including incrementing bursts, until the owning master drops cyc.
- Routes the owner's request to the slave and the slave's response back to the owner only.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_rr_pick.sv | 29 ++
 rtl/wb_ddr_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and Wishbone constants for the DDR port arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Round-robin successor of an index, wrapping at n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin selector; first requester at or after
// the pointer, wrapping, returned as a one-hot grant.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_src;

    // Requesters at or above the pointer win; otherwise wrap to the lowest one.
    always_comb begin
        for (int j = 0; j < N; j++) w_mask[j] = (j >= int'(i_ptr));
        w_hi    = i_req & w_mask;
        w_src   = (|w_hi) ? w_hi : i_req;
        o_grant = w_src & (-w_src);
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/wb_ddr_arbiter.sv
// wb_ddr_arbiter: round-robin Wishbone B3 arbiter sharing one DDR slave port.
// Define WB_DDR_ARB_TIMEOUT_EN to add the stall watchdog and timeout_o.
module wb_ddr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]          m_bte_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [DATA_WIDTH/8-1:0]           s_sel_o,
    output logic [2:0]                        s_cti_o,
    output logic [1:0]                        s_bte_o,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_rty_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o
`ifdef WB_DDR_ARB_TIMEOUT_EN
    ,
    output logic                              timeout_o
`endif
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_WIDTH / 8;

    arb_state_e             r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt, w_pick;
    logic [IW-1:0]          r_ptr, w_ptr_nxt;
    logic [IW-1:0]          r_owner, w_owner_nxt, w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_owner_cyc;
    logic                   w_to_hit;

    wb_rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .i_req   (m_cyc_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (w_pick[i]) w_pick_idx = IW'(i);
    end

    assign w_owner_cyc = |(m_cyc_i & r_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Ownership is released only by the owner dropping cyc; cti never ends it.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (r_state == IDLE) begin
            if (w_pick_valid) begin
                w_state_nxt = BUSY;
                w_grant_nxt = w_pick;
                w_owner_nxt = w_pick_idx;
            end
        end else if (!w_owner_cyc) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = IW'(rr_next(int'(r_owner), NUM_MASTERS));
        end
    end

    // r_grant is all-zero in IDLE, so it also gates every routed signal.
    always_comb begin
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = CTI_CLASSIC;
        s_bte_o = BTE_LINEAR;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                s_stb_o = m_stb_i[i];
                s_we_o  = m_we_i[i];
                s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o = m_sel_i[i*SW +: SW];
                s_cti_o = m_cti_i[i*3 +: 3];
                s_bte_o = m_bte_i[i*2 +: 2];
            end
        end
        m_ack_o = {NUM_MASTERS{s_ack_i}} & r_grant;
        m_err_o = {NUM_MASTERS{s_err_i | w_to_hit}} & r_grant;
        m_rty_o = {NUM_MASTERS{s_rty_i}} & r_grant;
        m_dat_o = s_dat_i;
    end

    assign s_cyc_o = w_owner_cyc;
    assign grant_o = r_grant;

`ifdef WB_DDR_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_timeout;
    logic          w_resp;

    assign w_resp   = s_ack_i | s_err_i | s_rty_i;
    assign w_to_hit = (r_state == BUSY) && (r_tcnt == TW'(TIMEOUT_CYCLES));

    // Counter holds the number of unanswered strobe cycles seen so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != BUSY || w_resp || w_to_hit)
                r_tcnt <= '0;
            else if (s_stb_o)
                r_tcnt <= r_tcnt + TW'(1);
            if (w_to_hit)
                r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_to_hit = 1'b0;
`endif

endmodule
